// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, read FSM states and word-index helper for mem_responder
package mem_pkg;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int REGFILE_WORDS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } rd_state_e;

  // Byte address to word index; callers zero-extend addresses of up to 32 bits.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction
endpackage

// File: rtl/mem_array_1r1w.sv
// rtl/mem_array_1r1w.sv - DEPTH x DATA_W word array, one synchronous read port and one write port
module mem_array_1r1w #(
  parameter int    DEPTH     = 256,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Block RAM power-up image; contents are never touched by reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Read returns the pre-write contents; the responder forwards same-edge writes itself.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word read / single-cycle word write responder for the cpu bus
module mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_W     = ADDR_W_DEF,
  parameter int    DATA_W     = DATA_W_DEF,
  parameter int    DEPTH      = 256,
  parameter int    RD_LATENCY = 2,
  parameter bit    ZERO_WORD0 = 1'b1,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              err_oob,
  output logic              err_misalign
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1   = 4'(RD_LATENCY - 1);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [AW-1:0]     cap_addr;
  logic              cap_mask;
  logic              resp_mask;
  logic              fwd;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] arr_q;

  logic [31:0] rd_idx, wr_idx;
  logic        rd_oob, wr_oob, rd_cap, wr_ok;

  assign rd_idx = word_index(32'(rd_addr));
  assign wr_idx = word_index(32'(wr_addr));
  assign rd_oob = rd_idx >= 32'(DEPTH);
  assign wr_oob = wr_idx >= 32'(DEPTH);
  assign rd_cap = (state == ST_IDLE) && rd_en;
  assign wr_ok  = wr_en && !wr_oob && !(ZERO_WORD0 && wr_idx == '0);

  mem_array_1r1w #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .re   (state == ST_RESP),
    .raddr(cap_addr),
    .rdata(arr_q),
    .we   (wr_ok),
    .waddr(wr_idx[AW-1:0]),
    .wdata(wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap_addr     <= '0;
      cap_mask     <= 1'b0;
      resp_mask    <= 1'b0;
      fwd          <= 1'b0;
      fwd_data     <= '0;
      rd_valid     <= 1'b0;
      err_oob      <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: if (rd_en) begin
          cap_addr <= rd_idx[AW-1:0];
          cap_mask <= rd_oob || (ZERO_WORD0 && rd_idx == '0);
          cnt      <= LAT_M1;
          state    <= (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        // Array samples on this edge; a write to the same word this edge wins.
        ST_RESP: begin
          rd_valid  <= 1'b1;
          resp_mask <= cap_mask;
          fwd       <= wr_ok && (wr_idx[AW-1:0] == cap_addr);
          fwd_data  <= wr_data;
          state     <= rd_en ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: if (!rd_en) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      if (rd_cap || wr_en) begin
        err_oob      <= err_oob | (rd_cap & rd_oob) | (wr_en & wr_oob);
        err_misalign <= err_misalign | (rd_cap & (rd_addr[1:0] != 2'b00))
                                     | (wr_en & (wr_addr[1:0] != 2'b00));
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_valid) rd_data = resp_mask ? '0 : (fwd ? fwd_data : arr_q);
  end
endmodule
